// File: rtl/adj_pkg.sv
// Shared types and default timing for the filter adjust-key controller.
// Imported by the debounce block and the top-level step FSM.
package adj_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    HOLD,
    REPEAT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } code_t;

  localparam int DEF_N_TGT         = 4;
  localparam int DEF_DB_CYCLES     = 50000;
  localparam int DEF_HOLD_FRAMES   = 30;
  localparam int DEF_REPEAT_FRAMES = 4;

  // Both keys down reads as a release.
  function automatic code_t key_code(
    input logic inc,
    input logic dec
  );
    code_t c;
    c = NONE;
    unique case (1'b1)
      inc & ~dec: c = UP;
      dec & ~inc: c = DOWN;
      default:    c = NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// 2-FF synchronizer plus reload-counter debounce for one active-low key.
// Output is active-high and starts "pressed" so a key held over reset never arms.
module key_debounce
  import adj_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pressed <= 1'b1;
    end else if (~s2 == pressed) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      cnt     <= '0;
      pressed <= ~s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adjust_key_ctrl.sv
// Key/switch front end: debounce, press-and-hold auto-repeat and
// frame-aligned inc/dec/enable routing to the pixel filter chain.
module adjust_key_ctrl
  import adj_pkg::*;
#(
  parameter int N_TGT         = DEF_N_TGT,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
  parameter int REPEAT_FRAMES = DEF_REPEAT_FRAMES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_en,
  input  logic                     key_inc_n,
  input  logic                     key_dec_n,
  input  logic [$clog2(N_TGT)-1:0] sel,
  input  logic [N_TGT-1:0]         en_sw,
  output logic [N_TGT-1:0]         inc_out,
  output logic [N_TGT-1:0]         dec_out,
  output logic [N_TGT-1:0]         enable_out,
  output logic                     busy
);

  localparam int SW   = $clog2(N_TGT);
  localparam int FMAX = (HOLD_FRAMES > REPEAT_FRAMES) ?
                        HOLD_FRAMES : REPEAT_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  logic inc_p;
  logic dec_p;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_inc (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_inc_n),
    .pressed(inc_p)
  );

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_dec (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_dec_n),
    .pressed(dec_p)
  );

  logic [SW-1:0]    sel_s1;
  logic [SW-1:0]    sel_s2;
  logic [N_TGT-1:0] en_s1;
  logic [N_TGT-1:0] en_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_s1 <= '0;
      sel_s2 <= '0;
      en_s1  <= '0;
      en_s2  <= '0;
    end else begin
      sel_s1 <= sel;
      sel_s2 <= sel_s1;
      en_s1  <= en_sw;
      en_s2  <= en_s1;
    end
  end

  code_t         code;
  state_t        state;
  state_t        state_nx;
  code_t         dir_q;
  code_t         dir_nx;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] sel_nx;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nx;
  logic [FW-1:0] fcnt_inc;
  logic          pending;
  logic          pending_nx;
  logic          armed;
  logic          held;
  logic          hold_hit;
  logic          rep_hit;
  logic          step;

  assign code     = key_code(inc_p, dec_p);
  assign held     = (code == dir_q);
  assign fcnt_inc = (fcnt == FW'(FMAX)) ? fcnt : fcnt + 1'b1;
  assign hold_hit = (int'(fcnt) + 1 >= HOLD_FRAMES);
  assign rep_hit  = (int'(fcnt) + 1 >= REPEAT_FRAMES);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx   = state;
    dir_nx     = dir_q;
    sel_nx     = sel_q;
    fcnt_nx    = fcnt;
    pending_nx = pending;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && code != NONE) begin
          dir_nx     = code;
          sel_nx     = sel_s2;
          pending_nx = 1'b1;
          fcnt_nx    = '0;
          state_nx   = FIRST;
        end
      end
      FIRST: begin
        // the first step is owed even if the key lets go early
        if (frame_en && pending) begin
          step       = 1'b1;
          pending_nx = 1'b0;
          state_nx   = held ? HOLD : IDLE;
        end else if (!pending) begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (frame_en) begin
          if (hold_hit) begin
            step     = 1'b1;
            fcnt_nx  = '0;
            state_nx = REPEAT;
          end else begin
            fcnt_nx = fcnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (frame_en) begin
          if (rep_hit) begin
            step    = 1'b1;
            fcnt_nx = '0;
          end else begin
            fcnt_nx = fcnt_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dir_q   <= NONE;
      sel_q   <= '0;
      fcnt    <= '0;
      pending <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nx;
      dir_q   <= dir_nx;
      sel_q   <= sel_nx;
      fcnt    <= fcnt_nx;
      pending <= pending_nx;
      armed   <= armed | (!inc_p && !dec_p);
    end
  end

  logic [N_TGT-1:0] onehot;
  logic             tgt_ok;

  assign onehot = N_TGT'(1) << sel_q;
  assign tgt_ok = (int'(sel_q) < N_TGT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_out    <= '0;
      dec_out    <= '0;
      enable_out <= '0;
    end else begin
      inc_out <= (step && dir_q == UP && tgt_ok) ? onehot : '0;
      dec_out <= (step && dir_q == DOWN && tgt_ok) ? onehot : '0;
      if (frame_en) begin
        enable_out <= en_s2;
      end
    end
  end

endmodule

// File: tb/tb_adjust_key_ctrl.sv
// Self-checking bench: pulse scoreboard keyed by frame number, an
// enable vector table and hand-written press/hold/reset sequences.
module tb_adjust_key_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_en;
  logic       key_inc_n;
  logic       key_dec_n;
  logic [1:0] sel;
  logic [3:0] en_sw;
  logic [3:0] inc_out;
  logic [3:0] dec_out;
  logic [3:0] enable_out;
  logic       busy;

  adjust_key_ctrl #(
    .N_TGT        (4),
    .DB_CYCLES    (4),
    .HOLD_FRAMES  (3),
    .REPEAT_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_en  (frame_en),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .sel       (sel),
    .en_sw     (en_sw),
    .inc_out   (inc_out),
    .dec_out   (dec_out),
    .enable_out(enable_out),
    .busy      (busy)
  );

  typedef struct {
    int         fr;
    logic [3:0] inc;
    logic [3:0] dec;
  } exp_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] exp;
  } ev_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fr    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    frame_en = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      frame_en = (cyc % 20 == 0);
      if (frame_en) fr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst && (inc_out | dec_out) != 4'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse: unexpected inc=%b dec=%b frame=%0d",
                 inc_out, dec_out, fr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.fr != fr || e.inc !== inc_out || e.dec !== dec_out ||
            frame_en !== 1'b1) begin
          bad++;
          $display("FAIL pulse: got frame=%0d inc=%b dec=%b want frame=%0d inc=%b dec=%b",
                   fr, inc_out, dec_out, e.fr, e.inc, e.dec);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fe();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_en) check("frame timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame();
    wait_fe();
    @(negedge clk);
  endtask

  task automatic watch_busy(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ev_t        tbl[4];
    logic [3:0] cur;
    int         f0;

    tbl[0] = '{4'b1010, 4'b1010};
    tbl[1] = '{4'b0101, 4'b0101};
    tbl[2] = '{4'b1111, 4'b1111};
    tbl[3] = '{4'b0110, 4'b0110};

    rst       = 1'b1;
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    sel       = 2'd0;
    en_sw     = 4'b0;
    #2 rst = 1'b0;
    cycles(3);
    check("rst inc_out", 32'(inc_out), 32'd0);
    check("rst dec_out", 32'(dec_out), 32'd0);
    check("rst enable_out", 32'(enable_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cycles(20);

    // 3-cycle glitch is shorter than the debounce window
    wait_frame();
    key_inc_n = 1'b0;
    cycles(3);
    key_inc_n = 1'b1;
    watch_busy(20, "glitch busy");
    check("glitch queue", 32'(q.size()), 32'd0);

    // single press, one step on the next frame
    sel = 2'd2;
    wait_frame();
    f0 = fr;
    q.push_back('{f0 + 1, 4'b0100, 4'b0000});
    key_inc_n = 1'b0;
    cycles(10);
    check("single busy rise", 32'(busy), 32'd1);
    cycles(20);
    key_inc_n = 1'b1;
    cycles(20);
    check("single busy fall", 32'(busy), 32'd0);
    check("single queue", 32'(q.size()), 32'd0);

    // hold dec: steps at frames 1,4,6,8,10; sel change ignored
    sel = 2'd1;
    wait_frame();
    f0 = fr;
    q.push_back('{f0 + 1, 4'b0000, 4'b0010});
    q.push_back('{f0 + 4, 4'b0000, 4'b0010});
    q.push_back('{f0 + 6, 4'b0000, 4'b0010});
    q.push_back('{f0 + 8, 4'b0000, 4'b0010});
    q.push_back('{f0 + 10, 4'b0000, 4'b0010});
    key_dec_n = 1'b0;
    cycles(60);
    sel = 2'd3;
    cycles(145);
    key_dec_n = 1'b1;
    cycles(30);
    check("repeat busy fall", 32'(busy), 32'd0);
    check("repeat queue", 32'(q.size()), 32'd0);

    // both keys act as a release; dropping dec restarts UP
    sel = 2'd0;
    wait_frame();
    f0 = fr;
    q.push_back('{f0 + 1, 4'b0001, 4'b0000});
    key_inc_n = 1'b0;
    cycles(25);
    key_dec_n = 1'b0;
    cycles(12);
    check("both busy", 32'(busy), 32'd0);
    q.push_back('{f0 + 3, 4'b0001, 4'b0000});
    key_dec_n = 1'b1;
    cycles(12);
    check("both restart busy", 32'(busy), 32'd1);
    cycles(15);
    key_inc_n = 1'b1;
    cycles(20);
    check("both busy fall", 32'(busy), 32'd0);
    check("both queue", 32'(q.size()), 32'd0);

    // frame-aligned enables
    cur = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wait_frame();
      cycles(9);
      en_sw = tbl[i].en;
      cycles(5);
      check("en mid-frame", 32'(enable_out), 32'(cur));
      wait_fe();
      check("en at frame_en", 32'(enable_out), 32'(cur));
      @(negedge clk);
      check("en after frame", 32'(enable_out), 32'(tbl[i].exp));
      cur = tbl[i].exp;
    end

    // reset during REPEAT with the key still held
    sel = 2'd0;
    wait_frame();
    f0 = fr;
    q.push_back('{f0 + 1, 4'b0000, 4'b0001});
    q.push_back('{f0 + 4, 4'b0000, 4'b0001});
    key_dec_n = 1'b0;
    cycles(84);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("async rst inc_out", 32'(inc_out), 32'd0);
    check("async rst dec_out", 32'(dec_out), 32'd0);
    check("async rst enable_out", 32'(enable_out), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("pre-reset queue", 32'(q.size()), 32'd0);
    cycles(3);
    rst = 1'b1;
    watch_busy(80, "held over reset busy");
    key_dec_n = 1'b1;
    cycles(15);
    wait_frame();
    f0 = fr;
    q.push_back('{f0 + 1, 4'b0000, 4'b0001});
    key_dec_n = 1'b0;
    cycles(25);
    key_dec_n = 1'b1;
    cycles(20);
    check("re-press busy fall", 32'(busy), 32'd0);
    check("re-press queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
